// File: rtl/bp_axil_nbf_receiver.sv
// AXI-Lite slave that assembles five 32-bit word-port writes into one NBF packet and emits it valid/ready.
// Optional feature macro BP_AXIL_NBF_RECEIVER_WSTRB_CHECK_EN: word-port writes with a partial strobe get SLVERR.
module bp_axil_nbf_receiver #(
  parameter int          S_AXIL_ADDR_WIDTH  = 64,
  parameter int          S_AXIL_DATA_WIDTH  = 32,
  parameter int          nbf_opcode_width_p = 8,
  parameter int          nbf_addr_width_p   = 64,
  parameter int          nbf_data_width_p   = 64,
  parameter logic [63:0] BASE_ADDR          = 64'h0
) (
  input  logic                           s_axil_aclk,
  input  logic                           s_axil_aresetn,
  input  logic [S_AXIL_ADDR_WIDTH-1:0]   s_axil_awaddr,
  input  logic [2:0]                     s_axil_awprot,
  input  logic                           s_axil_awvalid,
  output logic                           s_axil_awready,
  input  logic [S_AXIL_DATA_WIDTH-1:0]   s_axil_wdata,
  input  logic [S_AXIL_DATA_WIDTH/8-1:0] s_axil_wstrb,
  input  logic                           s_axil_wvalid,
  output logic                           s_axil_wready,
  output logic [1:0]                     s_axil_bresp,
  output logic                           s_axil_bvalid,
  input  logic                           s_axil_bready,
  input  logic [S_AXIL_ADDR_WIDTH-1:0]   s_axil_araddr,
  input  logic [2:0]                     s_axil_arprot,
  input  logic                           s_axil_arvalid,
  output logic                           s_axil_arready,
  output logic [S_AXIL_DATA_WIDTH-1:0]   s_axil_rdata,
  output logic [1:0]                     s_axil_rresp,
  output logic                           s_axil_rvalid,
  input  logic                           s_axil_rready,
  output logic [nbf_opcode_width_p-1:0]  nbf_opcode_o,
  output logic [nbf_addr_width_p-1:0]    nbf_addr_o,
  output logic [nbf_data_width_p-1:0]    nbf_data_o,
  output logic                           nbf_v_o,
  input  logic                           nbf_ready_i,
  output logic                           done_o
);

  localparam int              AW          = S_AXIL_ADDR_WIDTH;
  localparam int              DW          = S_AXIL_DATA_WIDTH;
  localparam logic [AW-1:0]   BASE_L      = BASE_ADDR[AW-1:0];
  localparam logic [1:0]      RESP_OKAY   = 2'b00;
  localparam logic [1:0]      RESP_SLVERR = 2'b10;
  localparam logic [1:0]      RESP_DECERR = 2'b11;

  logic            ready_en_q;
  logic            aw_held_q, aw_held_d;
  logic [AW-1:0]   aw_addr_q, aw_addr_d;
  logic            w_held_q, w_held_d;
  logic [DW-1:0]   w_data_q, w_data_d;
  logic [DW/8-1:0] w_strb_q, w_strb_d;
  logic            bvalid_q, bvalid_d;
  logic [1:0]      bresp_q, bresp_d;
  logic            rvalid_q, rvalid_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [1:0]      rresp_q, rresp_d;
  logic [2:0]      word_idx_q, word_idx_d;
  logic [63:0]     data_q, data_d;
  logic [63:0]     addr_q, addr_d;
  logic [7:0]      opcode_q, opcode_d;
  logic            nbf_v_q, nbf_v_d;
  logic [31:0]     count_q, count_d;
  logic            done_q, done_d;

  logic [AW-1:0]   aw_off, ar_off;
  logic            aw_is_word, ar_in_map, strb_ok, commit, handshake;
  logic            unused_ok;

  assign aw_off     = aw_addr_q - BASE_L;
  assign ar_off     = s_axil_araddr - BASE_L;
  assign aw_is_word = (aw_off == '0);
  assign ar_in_map  = (ar_off[AW-1:4] == '0);

`ifdef BP_AXIL_NBF_RECEIVER_WSTRB_CHECK_EN
  assign strb_ok = (w_strb_q == '1);
`else
  assign strb_ok = 1'b1;
`endif

  // Word-port writes wait for the outstanding packet to drain; other offsets never stall.
  assign commit    = aw_held_q && w_held_q && !bvalid_q && !(aw_is_word && nbf_v_q);
  assign handshake = nbf_v_q && nbf_ready_i;

  assign s_axil_awready = ready_en_q && !aw_held_q;
  assign s_axil_wready  = ready_en_q && !w_held_q;
  assign s_axil_arready = ready_en_q && !rvalid_q;
  assign s_axil_bvalid  = bvalid_q;
  assign s_axil_bresp   = bresp_q;
  assign s_axil_rvalid  = rvalid_q;
  assign s_axil_rdata   = rdata_q;
  assign s_axil_rresp   = rresp_q;
  assign nbf_v_o        = nbf_v_q;
  assign nbf_opcode_o   = opcode_q[nbf_opcode_width_p-1:0];
  assign nbf_addr_o     = addr_q[nbf_addr_width_p-1:0];
  assign nbf_data_o     = data_q[nbf_data_width_p-1:0];
  assign done_o         = done_q;

  assign unused_ok = &{1'b0, s_axil_awprot, s_axil_arprot, w_strb_q};

  always_comb begin
    aw_held_d  = aw_held_q;
    aw_addr_d  = aw_addr_q;
    w_held_d   = w_held_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    word_idx_d = word_idx_q;
    data_d     = data_q;
    addr_d     = addr_q;
    opcode_d   = opcode_q;
    nbf_v_d    = nbf_v_q;
    count_d    = count_q;
    done_d     = done_q;

    if (s_axil_awvalid && s_axil_awready) begin
      aw_held_d = 1'b1;
      aw_addr_d = s_axil_awaddr;
    end
    if (s_axil_wvalid && s_axil_wready) begin
      w_held_d = 1'b1;
      w_data_d = s_axil_wdata;
      w_strb_d = s_axil_wstrb;
    end
    if (bvalid_q && s_axil_bready) begin
      bvalid_d = 1'b0;
    end

    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      if (!aw_is_word) begin
        bresp_d = RESP_DECERR;
      end else if (!strb_ok) begin
        bresp_d = RESP_SLVERR;
      end else begin
        bresp_d = RESP_OKAY;
        case (word_idx_q)
          3'd0: begin data_d[31:0]  = w_data_q[31:0]; word_idx_d = 3'd1; end
          3'd1: begin data_d[63:32] = w_data_q[31:0]; word_idx_d = 3'd2; end
          3'd2: begin addr_d[31:0]  = w_data_q[31:0]; word_idx_d = 3'd3; end
          3'd3: begin addr_d[63:32] = w_data_q[31:0]; word_idx_d = 3'd4; end
          default: begin
            opcode_d   = w_data_q[7:0];
            nbf_v_d    = 1'b1;
            word_idx_d = 3'd0;
          end
        endcase
      end
    end

    if (handshake) begin
      nbf_v_d = 1'b0;
      count_d = count_q + 32'd1;
      if (opcode_q == 8'hFF) begin
        done_d = 1'b1;
      end
    end

    if (rvalid_q && s_axil_rready) begin
      rvalid_d = 1'b0;
    end
    // Read data is captured from the current registers, so a same-cycle count bump is not visible.
    if (s_axil_arvalid && s_axil_arready) begin
      rvalid_d = 1'b1;
      rdata_d  = '0;
      rresp_d  = RESP_OKAY;
      if (!ar_in_map) begin
        rresp_d = RESP_DECERR;
      end else begin
        case (ar_off[3:0])
          4'h4:    rdata_d = count_q;
          4'h8:    rdata_d = {28'b0, nbf_v_q, word_idx_q};
          4'hC:    rdata_d = {31'b0, done_q};
          default: rresp_d = RESP_DECERR;
        endcase
      end
    end
  end

  always_ff @(posedge s_axil_aclk) begin
    if (!s_axil_aresetn) begin
      ready_en_q <= 1'b0;
      aw_held_q  <= 1'b0;
      aw_addr_q  <= '0;
      w_held_q   <= 1'b0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= 2'b00;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= 2'b00;
      word_idx_q <= 3'd0;
      data_q     <= '0;
      addr_q     <= '0;
      opcode_q   <= '0;
      nbf_v_q    <= 1'b0;
      count_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
      aw_held_q  <= aw_held_d;
      aw_addr_q  <= aw_addr_d;
      w_held_q   <= w_held_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      word_idx_q <= word_idx_d;
      data_q     <= data_d;
      addr_q     <= addr_d;
      opcode_q   <= opcode_d;
      nbf_v_q    <= nbf_v_d;
      count_q    <= count_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_bp_axil_nbf_receiver.sv
// Self-checking bench for bp_axil_nbf_receiver: directed scenarios plus randomized packets against a word-queue model.
module tb_bp_axil_nbf_receiver;
  localparam logic [63:0] BASE = 64'h0000_0000_4000_0000;

  logic        clk;
  logic        aresetn;
  logic [63:0] awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic [7:0]  nbf_opcode;
  logic [63:0] nbf_addr, nbf_data;
  logic        nbf_v, nbf_ready, done;

  bp_axil_nbf_receiver #(.BASE_ADDR(BASE)) dut (
    .s_axil_aclk(clk), .s_axil_aresetn(aresetn),
    .s_axil_awaddr(awaddr), .s_axil_awprot(awprot), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
    .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
    .s_axil_araddr(araddr), .s_axil_arprot(arprot), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
    .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
    .nbf_opcode_o(nbf_opcode), .nbf_addr_o(nbf_addr), .nbf_data_o(nbf_data),
    .nbf_v_o(nbf_v), .nbf_ready_i(nbf_ready), .done_o(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  op;
    logic [63:0] addr;
    logic [63:0] data;
  } pkt_t;

  int          errors = 0;
  int          checks = 0;
  pkt_t        exp_q[$];
  pkt_t        obs_q[$];
  logic [31:0] cur_w[$];
  int          model_count = 0;
  pkt_t        mon_pkt, held_pkt;
  bit          holding = 0;

  task automatic check(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: a packet is just the five accepted words, read back as data/addr/opcode fields.
  task automatic model_word(input logic [31:0] w);
    pkt_t p;
    cur_w.push_back(w);
    if (cur_w.size() == 5) begin
      p.data = {cur_w[1], cur_w[0]};
      p.addr = {cur_w[3], cur_w[2]};
      p.op   = cur_w[4][7:0];
      exp_q.push_back(p);
      model_count++;
      cur_w.delete();
    end
  endtask

  // Packet monitor: record every handshake and require fields to stay put while stalled.
  always @(negedge clk) begin
    if (!aresetn) begin
      holding = 0;
    end else begin
      mon_pkt.op   = nbf_opcode;
      mon_pkt.addr = nbf_addr;
      mon_pkt.data = nbf_data;
      if (holding) begin
        check("nbf_v_hold", nbf_v, 1);
        check("nbf_fields_hold", mon_pkt, held_pkt);
      end
      if (nbf_v && nbf_ready) begin
        obs_q.push_back(mon_pkt);
        holding = 0;
      end else if (nbf_v) begin
        held_pkt = mon_pkt;
        holding  = 1;
      end else begin
        holding = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_aw_w(input logic [63:0] a, input logic [31:0] d, input logic [3:0] s);
    bit aw_p, w_p, aa, wa;
    int n;
    awaddr = a; awvalid = 1; wdata = d; wstrb = s; wvalid = 1;
    aw_p = 1; w_p = 1; n = 0;
    while ((aw_p || w_p) && n < 40) begin
      aa = awvalid && awready;
      wa = wvalid && wready;
      tick();
      if (aa) begin awvalid = 0; aw_p = 0; end
      if (wa) begin wvalid = 0; w_p = 0; end
      n++;
    end
    awvalid = 0; wvalid = 0;
    check("aw_w_accepted", {aw_p, w_p}, 0);
  endtask

  task automatic wait_b(output logic [1:0] resp);
    int n = 0;
    while (!bvalid && n < 40) begin
      if (n == 6) nbf_ready = 1;
      tick();
      n++;
    end
    check("b_arrives", bvalid, 1);
    resp = bresp;
    tick();
  endtask

  task automatic axi_write(input logic [63:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    send_aw_w(a, d, s);
    wait_b(resp);
  endtask

  task automatic axi_read(input logic [63:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n = 0;
    araddr = a; arvalid = 1;
    while (!arready && n < 40) begin tick(); n++; end
    tick();
    arvalid = 0;
    n = 0;
    while (!rvalid && n < 40) begin tick(); n++; end
    check("r_arrives", rvalid, 1);
    d = rdata; resp = rresp;
    tick();
  endtask

  task automatic wr_word(input logic [31:0] d);
    logic [1:0] resp;
    axi_write(BASE, d, 4'hF, resp);
    check("word_bresp", resp, 2'b00);
    model_word(d);
  endtask

  task automatic rd_check(input string tag, input logic [63:0] a, input logic [31:0] exp_d,
                          input logic [1:0] exp_r);
    logic [31:0] d;
    logic [1:0]  r;
    axi_read(a, d, r);
    check({tag, "_rresp"}, r, exp_r);
    check({tag, "_rdata"}, d, exp_d);
  endtask

  task automatic check_pkts(input string tag);
    nbf_ready = 1;
    repeat (4) tick();
    check({tag, "_pkt_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check({tag, "_pkt"}, obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic timed_write(input int lead, input logic [31:0] d);
    awaddr = BASE; wdata = d; wstrb = 4'hF;
    if (lead > 0) begin
      check("wready_idle", wready, 1);
      wvalid = 1;
      tick();
      wvalid = 0;
      repeat (lead - 1) tick();
      check("no_b_before_aw", bvalid, 0);
      check("awready_idle", awready, 1);
      awvalid = 1;
      tick();
      awvalid = 0;
    end else begin
      awvalid = 1; wvalid = 1;
      tick();
      awvalid = 0; wvalid = 0;
    end
    check("b_not_same_cycle", bvalid, 0);
    tick();
    check("b_next_cycle", bvalid, 1);
    check("b_okay", bresp, 2'b00);
    tick();
    check("b_single", bvalid, 0);
    model_word(d);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] bad_w [5] = '{64'h4, 64'h8, 64'hC, 64'h10, 64'h1000};
    logic [63:0] bad_r [5] = '{64'h0, 64'h3, 64'h10, 64'h24, 64'h100};
    logic [31:0] w;
    logic [1:0]  resp;

    aresetn = 0; awaddr = 0; awprot = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0;
    araddr = 0; arprot = 0; arvalid = 0; bready = 1; rready = 1; nbf_ready = 1;
    repeat (3) tick();
    check("rst_awready", awready, 0);
    check("rst_wready", wready, 0);
    check("rst_arready", arready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_nbf_v", nbf_v, 0);
    check("rst_done", done, 0);
    check("rst_resps", {bresp, rresp}, 0);
    aresetn = 1;
    tick();
    check("post_rst_readies", {awready, wready, arready}, 3'b111);

    // Directed reference packet.
    wr_word(32'hDDDD0001); wr_word(32'hDDDD0002); wr_word(32'h80000000);
    wr_word(32'h00000000); wr_word(32'h00000003);
    repeat (3) tick();
    if (obs_q.size() > 0) check("ref_pkt_literal", obs_q[0], {8'h03, 64'h80000000, 64'hDDDD0002DDDD0001});
    check_pkts("ref");
    rd_check("count_after_ref", BASE + 64'h4, 32'd1, 2'b00);

    // AW/W ordering.
    timed_write(3, 32'h1111_2222);
    timed_write(0, 32'h3333_4444);
    for (int k = 0; k < 3; k++) wr_word($urandom());
    check_pkts("ordering");

    // Randomized packets with random backpressure and interleaved bad accesses.
    for (int p = 0; p < 6; p++) begin
      for (int k = 0; k < 5; k++) begin
        nbf_ready = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) == 0) begin
          axi_write(BASE + bad_w[$urandom_range(0, 4)], $urandom(), 4'hF, resp);
          check("rand_bad_bresp", resp, 2'b11);
        end
        if ($urandom_range(0, 3) == 0)
          rd_check("rand_bad_rd", BASE + bad_r[$urandom_range(0, 4)], 32'h0, 2'b11);
        w = $urandom();
        if (k == 4) w[7:0] = 8'($urandom_range(0, 254));
        wr_word(w);
      end
    end
    check_pkts("random");
    rd_check("count_after_random", BASE + 64'h4, 32'(model_count), 2'b00);
    rd_check("below_base", BASE - 64'h4, 32'h0, 2'b11);

    // Backpressure stall, and a count read coinciding with the handshake.
    nbf_ready = 0;
    for (int k = 0; k < 5; k++) wr_word($urandom());
    w = $urandom();
    send_aw_w(BASE, w, 4'hF);
    repeat (4) begin check("stall_no_b", bvalid, 0); tick(); end
    rd_check("status_pending", BASE + 64'h8, 32'h8, 2'b00);
    araddr = BASE + 64'h4; arvalid = 1; nbf_ready = 1;
    tick();
    arvalid = 0;
    check("same_cycle_rvalid", rvalid, 1);
    check("same_cycle_count", rdata, 32'(model_count - 1));
    tick();
    wait_b(resp);
    check("stall_released_bresp", resp, 2'b00);
    model_word(w);
    rd_check("status_after_stall", BASE + 64'h8, 32'h1, 2'b00);
    rd_check("count_after_stall", BASE + 64'h4, 32'(model_count), 2'b00);
    for (int k = 0; k < 4; k++) wr_word($urandom());
    check_pkts("stall");

    // Finish opcode and error decode.
    check("done_before_ff", done, 0);
    rd_check("done_reg_0", BASE + 64'hC, 32'h0, 2'b00);
    for (int k = 0; k < 4; k++) wr_word($urandom());
    wr_word(32'hABCD_EFFF);
    check_pkts("finish");
    check("done_after_ff", done, 1);
    rd_check("done_reg_1", BASE + 64'hC, 32'h1, 2'b00);
    axi_write(BASE + 64'h10, 32'h5A5A5A5A, 4'hF, resp);
    check("decerr_write", resp, 2'b11);
    rd_check("decerr_read", BASE + 64'h20, 32'h0, 2'b11);
    for (int k = 0; k < 5; k++) wr_word($urandom());
    check_pkts("after_done");
    check("done_sticky", done, 1);

    // Partial strobe on the word port.
    w = $urandom();
    axi_write(BASE, w, 4'h7, resp);
`ifdef BP_AXIL_NBF_RECEIVER_WSTRB_CHECK_EN
    check("strb_bresp", resp, 2'b10);
`else
    check("strb_bresp", resp, 2'b00);
    model_word(w);
`endif
    rd_check("strb_word_idx", BASE + 64'h8, 32'(cur_w.size()), 2'b00);
    repeat (5 - cur_w.size()) wr_word($urandom());
    check_pkts("strb");

    // Reset in the middle of a packet.
    for (int k = 0; k < 3; k++) wr_word($urandom());
    aresetn = 0;
    tick();
    check("midrst_readies", {awready, wready, arready}, 0);
    check("midrst_valids", {bvalid, rvalid, nbf_v, done}, 0);
    tick();
    aresetn = 1;
    cur_w.delete();
    model_count = 0;
    tick();
    check("midrst_release_readies", {awready, wready, arready}, 3'b111);
    rd_check("midrst_status", BASE + 64'h8, 32'h0, 2'b00);
    rd_check("midrst_count", BASE + 64'h4, 32'h0, 2'b00);
    rd_check("midrst_done", BASE + 64'hC, 32'h0, 2'b00);
    for (int k = 0; k < 5; k++) wr_word($urandom());
    check_pkts("midrst");
    rd_check("midrst_count_after", BASE + 64'h4, 32'(model_count), 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bp_axil_nbf_receiver.md
BP_AXIL_NBF_RECEIVER -- requirements
Module: bp_axil_nbf_receiver

Interface
REQ-001 SHALL have parameter S_AXIL_ADDR_WIDTH, default 64, AXI-Lite address width.
REQ-002 SHALL have parameter S_AXIL_DATA_WIDTH, default 32, AXI-Lite data width; only 32 is supported.
REQ-003 SHALL have parameters nbf_opcode_width_p, nbf_addr_width_p and nbf_data_width_p, defaults 8/64/64, giving the NBF field widths.
REQ-004 SHALL have parameter BASE_ADDR, default 64'h0, register map base.
REQ-005 SHALL have port s_axil_aclk, input, 1 bit, the only clock; all logic is on its rising edge.
REQ-006 SHALL have port s_axil_aresetn, input, 1 bit; reset is synchronous and active-low.
REQ-007 SHALL have AW channel ports: s_axil_awaddr in [ADDR_W], s_axil_awvalid in 1, s_axil_awready out 1, s_axil_awprot in 3 (ignored).
REQ-008 SHALL have W channel ports: s_axil_wdata in 32, s_axil_wstrb in 4, s_axil_wvalid in 1, s_axil_wready out 1.
REQ-009 SHALL have B channel ports: s_axil_bresp out 2, s_axil_bvalid out 1, s_axil_bready in 1.
REQ-010 SHALL have AR channel ports: s_axil_araddr in [ADDR_W], s_axil_arvalid in 1, s_axil_arready out 1, s_axil_arprot in 3 (ignored).
REQ-011 SHALL have R channel ports: s_axil_rdata out 32, s_axil_rresp out 2, s_axil_rvalid out 1, s_axil_rready in 1.
REQ-012 SHALL have NBF output ports: nbf_opcode_o out 8, nbf_addr_o out 64, nbf_data_o out 64, nbf_v_o out 1, nbf_ready_i in 1 (valid/ready).
REQ-013 SHALL have done_o, out 1: sticky finish indication.

Function
REQ-014 Register map (offset from BASE_ADDR): 0x0 W = NBF word port; 0x4 R = packets-emitted count (32b, wraps 0xFFFFFFFF->0); 0x8 R = status {28'b0, nbf_v_o, word_idx[2:0]}; 0xC R = {31'b0, done_o}.
REQ-015 Each NBF packet SHALL be 5 writes to 0x0, in this order: data[31:0], data[63:32], addr[31:0], addr[63:32], opcode (wdata[7:0]; upper bits ignored).
REQ-016 AW and W SHALL be captured independently, in any order or in the same cycle; awready = no AW held, wready = no W held.
REQ-017 Write commit SHALL occur when AW and W are both held and bvalid=0; a commit to 0x0 additionally requires nbf_v_o=0, otherwise it stalls with no bresp.
REQ-018 On commit, bvalid SHALL assert the next cycle and hold until bready; bresp = OKAY for 0x0, DECERR (2'b11) for any other offset (data dropped, no state change); held AW/W are released on commit.
REQ-019 word_idx SHALL increment 0..4 on each 0x0 commit; the 5th commit sets nbf_v_o=1 the next cycle with the assembled fields and returns word_idx to 0.
REQ-020 nbf_v_o and the NBF fields SHALL stay stable until nbf_ready_i is high; on that handshake nbf_v_o clears and the packet count increments.
REQ-021 A handshake with opcode 8'hFF SHALL set done_o, which stays set until reset; later packets are still accepted.
REQ-022 Read: arready = !rvalid; accepting AR sets rvalid the next cycle with rdata registered; rvalid holds until rready; rresp = OKAY for 0x4/0x8/0xC, DECERR with rdata=0 otherwise.
REQ-023 A read of 0x4 in the same cycle as a count increment SHALL return the pre-increment value.
REQ-024 Address decode SHALL use awaddr/araddr minus BASE_ADDR, bits [3:0]; a nonzero result in higher bits is DECERR.

Reset
REQ-025 While s_axil_aresetn=0 at a clock edge: awready=wready=arready=0, bvalid=rvalid=nbf_v_o=done_o=0, word_idx=0, count=0, held AW/W cleared, bresp=rresp=0.
REQ-026 Reset mid-packet or mid-transaction SHALL discard the partial packet and any pending response; readies assert on the first cycle after reset is released.

Configuration
REQ-027 With BP_AXIL_NBF_RECEIVER_WSTRB_CHECK_EN defined, a 0x0 write with wstrb != 4'hF SHALL return SLVERR (2'b10) and leave word_idx and the packet state unchanged; without the macro, wstrb is ignored and every 0x0 write is OKAY.

Verification
REQ-028 5 writes to 0x0 (0xDDDD0001, 0xDDDD0002, 0x80000000, 0x0, 0x03) with nbf_ready_i=1 -> one nbf_v_o pulse with opcode=0x03, addr=0x80000000, data=0xDDDD0002DDDD0001; read 0x4 = 1.
REQ-029 W issued 3 cycles before AW, and separately AW/W in the same cycle -> each gives a single OKAY B one cycle after both are held.
REQ-030 nbf_ready_i=0 with packet pending, then a 6th write to 0x0 -> no bvalid and read 0x8 = 0x8; after nbf_ready_i=1 -> B OKAY follows and word_idx=1.
REQ-031 Packet with opcode 0xFF handshaken -> done_o=1 and read 0xC = 1; write to 0x10 -> bresp=2'b11; read 0x20 -> rresp=2'b11, rdata=0.
REQ-032 Reset asserted after 3 words -> after release read 0x8 = 0, and 5 new words produce exactly one correct packet.
REQ-033 With macro: 0x0 write with wstrb=4'h7 -> bresp=2'b10, word_idx unchanged; without macro -> OKAY and word_idx increments.
